// File: rtl/lwir_lossless_compression.sv
// Streaming lossless compressor for 16-bit LWIR pixels.
// Pipeline: previous-pixel delta -> zigzag map -> limited-length Rice code -> MSB-first packer.
// Idle flush emits the partial word left-justified and restarts prediction from zero.
// Optional build macro LWIR_SEGMENT_TRAILER_EN appends a {16'hA5C3, pixel_count} trailer
// word after each flushed segment.
module lwir_lossless_compression #(
  parameter int unsigned K          = 4,
  parameter int unsigned ESC_Q      = 16,
  parameter int unsigned FLUSH_IDLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] pixel_in,
  output logic        valid_out,
  output logic [31:0] stream_out
);

  localparam int unsigned IdleW = (FLUSH_IDLE == 0) ? 1 : $clog2(FLUSH_IDLE + 1);

  // Stage 0: prediction and mapping
  logic [15:0]      prev_q;
  logic [15:0]      u_q;
  logic             v1_q;
  logic [15:0]      prev_eff;
  logic [15:0]      e;
  logic [15:0]      u_d;

  // Stage 1: Rice code
  logic [31:0]      code_q;
  logic [5:0]       len_q;
  logic             v2_q;
  logic [31:0]      code_d;
  logic [5:0]       len_d;
  logic [15:0]      q;
  logic [31:0]      r32;

  // Packer
  logic [63:0]      acc_q;
  logic [63:0]      acc_d;
  logic [63:0]      acc_app;
  logic [6:0]       fill_q;
  logic [6:0]       fill_d;
  logic [6:0]       fill_app;
  logic [6:0]       shamt;
  logic             emit;
  logic [31:0]      word;

  // Idle / flush control
  logic [IdleW-1:0] idle_q;
  logic             idle_hit;
  logic             pipe_empty;
  logic             flush_fire;

`ifdef LWIR_SEGMENT_TRAILER_EN
  logic [15:0]      cnt_q;
  logic [15:0]      trl_cnt_q;
  logic             trl_q;
`endif

  assign idle_hit   = (idle_q == IdleW'(FLUSH_IDLE));
  assign pipe_empty = !v1_q && !v2_q;

`ifdef LWIR_SEGMENT_TRAILER_EN
  assign flush_fire = idle_hit && ((fill_q != 7'd0) || (cnt_q != 16'd0));
`else
  assign flush_fire = idle_hit && (fill_q != 7'd0);
`endif

  // Delta prediction and zigzag mapping; a pixel arriving on the flush cycle predicts from 0
  always_comb begin
    prev_eff = idle_hit ? 16'd0 : prev_q;
    e        = pixel_in - prev_eff;
    u_d      = {e[14:0], 1'b0} ^ {16{e[15]}};
  end

  // Stage 0 register: mapped value and predictor state
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 16'd0;
      u_q    <= 16'd0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        u_q    <= u_d;
        prev_q <= pixel_in;
      end else if (idle_hit) begin
        prev_q <= 16'd0;
      end
    end
  end

  // Idle counter: advances only once the pipeline has drained
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (valid_in || idle_hit) begin
      idle_q <= '0;
    end else if (pipe_empty) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  // Rice code, right-aligned in code_d; escape sends u raw after ESC_Q ones
  always_comb begin
    q   = u_q >> K;
    r32 = {16'd0, u_q} & ((32'd1 << K) - 32'd1);
    if (q < 16'(ESC_Q)) begin
      code_d = ((~(32'hFFFF_FFFF << q)) << (K + 1)) | r32;
      len_d  = 6'(q) + 6'(K + 1);
    end else begin
      code_d = ((~(32'hFFFF_FFFF << ESC_Q)) << 16) | {16'd0, u_q};
      len_d  = 6'(ESC_Q + 16);
    end
  end

  // Stage 1 register: code and length
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= 32'd0;
      len_q  <= 6'd0;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        code_q <= code_d;
        len_q  <= len_d;
      end
    end
  end

  // Packer: append new code behind existing bits, then emit flush/trailer/full word
  always_comb begin
    shamt = 7'd64 - fill_q - {1'b0, len_q};
    if (v2_q) begin
      acc_app  = acc_q | ({32'd0, code_q} << shamt);
      fill_app = fill_q + {1'b0, len_q};
    end else begin
      acc_app  = acc_q;
      fill_app = fill_q;
    end
    acc_d  = acc_app;
    fill_d = fill_app;
    emit   = 1'b0;
    word   = stream_out;
`ifdef LWIR_SEGMENT_TRAILER_EN
    // Trailer follows the flush cycle, when the pipeline is still empty, so no data word
    // is pending here; if one ever were, it waits in the accumulator headroom.
    if (trl_q) begin
      emit = 1'b1;
      word = {16'hA5C3, trl_cnt_q};
    end else if (flush_fire) begin
      emit   = (fill_q != 7'd0);
      word   = acc_q[63:32];
      acc_d  = 64'd0;
      fill_d = 7'd0;
    end else if (fill_app >= 7'd32) begin
      emit   = 1'b1;
      word   = acc_app[63:32];
      acc_d  = acc_app << 32;
      fill_d = fill_app - 7'd32;
    end
`else
    // On a flush cycle the pipeline is empty, so acc_q holds everything
    if (flush_fire) begin
      emit   = 1'b1;
      word   = acc_q[63:32];
      acc_d  = 64'd0;
      fill_d = 7'd0;
    end else if (fill_app >= 7'd32) begin
      emit   = 1'b1;
      word   = acc_app[63:32];
      acc_d  = acc_app << 32;
      fill_d = fill_app - 7'd32;
    end
`endif
  end

  // Packer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= 64'd0;
      fill_q     <= 7'd0;
      valid_out  <= 1'b0;
      stream_out <= 32'd0;
    end else begin
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      valid_out <= emit;
      if (emit) begin
        stream_out <= word;
      end
    end
  end

`ifdef LWIR_SEGMENT_TRAILER_EN
  // Segment pixel counter; snapshot on flush, a pixel on the flush cycle starts the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 16'd0;
      trl_cnt_q <= 16'd0;
      trl_q     <= 1'b0;
    end else begin
      trl_q <= flush_fire;
      if (flush_fire) begin
        trl_cnt_q <= cnt_q;
        cnt_q     <= valid_in ? 16'd1 : 16'd0;
      end else if (valid_in) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lwir_lossless_compression.sv
// Directed self-checking bench for lwir_lossless_compression.
module tb_lwir_lossless_compression;

`ifdef LWIR_SEGMENT_TRAILER_EN
  localparam int Trl = 1;
`else
  localparam int Trl = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] pixel_in;
  logic        valid_out;
  logic [31:0] stream_out;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          nwords = 0;
  logic [31:0] words [16];
  int          wcyc [16];

  lwir_lossless_compression dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .pixel_in   (pixel_in),
    .valid_out  (valid_out),
    .stream_out (stream_out)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, record any emitted word 1 ns later
  task automatic tick(input logic v, input logic [15:0] p);
    valid_in = v;
    pixel_in = p;
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) begin
      if (nwords < 16) begin
        words[nwords] = stream_out;
        wcyc[nwords]  = cyc;
      end
      nwords++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
  endtask

  task automatic clear_log();
    nwords = 0;
    cyc    = 0;
    for (int i = 0; i < 16; i++) begin
      words[i] = 'x;
      wcyc[i]  = -1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(1'b0, 16'h0000);
    tick(1'b0, 16'h0000);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 16'h1234);
    tick(1'b1, 16'h1234);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_out: got %b want 0", valid_out);
    end
    vectors++;
    if (stream_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_stream_out: got %h want 00000000", stream_out);
    end
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_single();
    apply_reset();
    tick(1'b1, 16'h0003);
    idle(14);
    vectors++;
    if (nwords !== 1 + Trl) begin
      miscompares++;
      $display("FAIL single_count: got %0d words want %0d", nwords, 1 + Trl);
    end
    vectors++;
    if (words[0] !== 32'h3000_0000) begin
      miscompares++;
      $display("FAIL single_word: got %h want 30000000", words[0]);
    end
`ifdef LWIR_SEGMENT_TRAILER_EN
    vectors++;
    if (words[1] !== 32'hA5C3_0001) begin
      miscompares++;
      $display("FAIL single_trailer: got %h want a5c30001", words[1]);
    end
`endif
  endtask

  task automatic test_escape();
    apply_reset();
    tick(1'b1, 16'h0100);
    idle(14);
    vectors++;
    if (words[0] !== 32'hFFFF_0200) begin
      miscompares++;
      $display("FAIL escape_word: got %h want ffff0200", words[0]);
    end
    vectors++;
    if (wcyc[0] !== 2) begin
      miscompares++;
      $display("FAIL escape_latency: got cycle %0d want 2", wcyc[0]);
    end
    vectors++;
    if (nwords !== 1 + Trl) begin
      miscompares++;
      $display("FAIL escape_count: got %0d words want %0d", nwords, 1 + Trl);
    end
`ifdef LWIR_SEGMENT_TRAILER_EN
    vectors++;
    if (words[1] !== 32'hA5C3_0001) begin
      miscompares++;
      $display("FAIL escape_trailer: got %h want a5c30001", words[1]);
    end
`endif
  endtask

  task automatic test_pair();
    apply_reset();
    tick(1'b1, 16'h0005);
    tick(1'b1, 16'h0004);
    idle(14);
    vectors++;
    if (words[0] !== 32'h5040_0000) begin
      miscompares++;
      $display("FAIL pair_word: got %h want 50400000", words[0]);
    end
    vectors++;
    if (nwords !== 1 + Trl) begin
      miscompares++;
      $display("FAIL pair_count: got %0d words want %0d", nwords, 1 + Trl);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    tick(1'b1, 16'hFFFF);
    tick(1'b1, 16'h0000);
    idle(14);
    vectors++;
    if (words[0] !== 32'h0880_0000) begin
      miscompares++;
      $display("FAIL wrap_word: got %h want 08800000", words[0]);
    end
`ifdef LWIR_SEGMENT_TRAILER_EN
    vectors++;
    if (words[1] !== 32'hA5C3_0002) begin
      miscompares++;
      $display("FAIL wrap_trailer: got %h want a5c30002", words[1]);
    end
`endif
  endtask

  task automatic test_eight();
    apply_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h0010);
    idle(14);
    vectors++;
    if (nwords !== 2 + Trl) begin
      miscompares++;
      $display("FAIL eight_count: got %0d words want %0d", nwords, 2 + Trl);
    end
    vectors++;
    if (words[0] !== 32'hC000_0000) begin
      miscompares++;
      $display("FAIL eight_word0: got %h want c0000000", words[0]);
    end
    // 7+5*5 = 32 bits completed by the sixth pixel (cycle 5), visible two edges later
    vectors++;
    if (wcyc[0] !== 7) begin
      miscompares++;
      $display("FAIL eight_word0_cycle: got %0d want 7", wcyc[0]);
    end
    vectors++;
    if (words[1] !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL eight_flush: got %h want 00000000", words[1]);
    end
`ifdef LWIR_SEGMENT_TRAILER_EN
    vectors++;
    if (words[2] !== 32'hA5C3_0008) begin
      miscompares++;
      $display("FAIL eight_trailer: got %h want a5c30008", words[2]);
    end
`endif
  endtask

  task automatic test_mid_reset();
    apply_reset();
    tick(1'b1, 16'h0003);
    tick(1'b1, 16'h0005);
    tick(1'b1, 16'h0004);
    rst = 1'b1;
    tick(1'b0, 16'h0000);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_valid: got %b want 0", valid_out);
    end
    tick(1'b0, 16'h0000);
    rst = 1'b0;
    clear_log();
    idle(14);
    vectors++;
    if (nwords !== 0) begin
      miscompares++;
      $display("FAIL midreset_no_output: got %0d words want 0", nwords);
    end
    clear_log();
    tick(1'b1, 16'h0003);
    idle(14);
    vectors++;
    if (words[0] !== 32'h3000_0000) begin
      miscompares++;
      $display("FAIL midreset_word: got %h want 30000000", words[0]);
    end
    vectors++;
    if (nwords !== 1 + Trl) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d words want %0d", nwords, 1 + Trl);
    end
  endtask

  // Pixel presented on the flush cycle: flush uses old bits, new pixel predicts from 0
  task automatic test_back_to_back();
    apply_reset();
    tick(1'b1, 16'h0003);
    idle(10);
    tick(1'b1, 16'h0005);
    idle(14);
    vectors++;
    if (words[0] !== 32'h3000_0000) begin
      miscompares++;
      $display("FAIL b2b_first: got %h want 30000000", words[0]);
    end
    vectors++;
    if (wcyc[0] !== 11) begin
      miscompares++;
      $display("FAIL b2b_flush_cycle: got %0d want 11", wcyc[0]);
    end
    vectors++;
    if (words[1 + Trl] !== 32'h5000_0000) begin
      miscompares++;
      $display("FAIL b2b_second: got %h want 50000000", words[1 + Trl]);
    end
    vectors++;
    if (nwords !== 2 + 2 * Trl) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words want %0d", nwords, 2 + 2 * Trl);
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    pixel_in = 16'h0000;
    clear_log();
    test_reset();
    test_single();
    test_escape();
    test_pair();
    test_wrap();
    test_eight();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lwir_lossless_compression.md
Name: lwir_lossless_compression

Overview:
- Streaming lossless compressor for 16-bit LWIR pixels. One pixel per cycle max; no back-pressure.
- Pipeline: previous-pixel delta prediction, zigzag mapping, limited-length Rice coding with fixed parameter, then an MSB-first bit packer.
- Output is a 32-bit word stream sitting between the sensor front end and the frame storage/transmit path.

Parameters:
- K, 4: Rice parameter (number of remainder bits), 0..8.
- ESC_Q, 16: escape threshold on quotient. Requires ESC_Q+16 <= 32 and ESC_Q-1+1+K <= 32.
- FLUSH_IDLE, 8: consecutive idle cycles, after the pipeline empties, before a partial word is flushed.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  pixel_in is valid this cycle.
- pixel_in  input  16  unsigned pixel, raster order.
- valid_out  output  1  stream_out holds a valid word this cycle (one-cycle pulse per word).
- stream_out  output  32  packed code word; first bit in bit 31.

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-high. On reset:
  - valid_out=0, stream_out=0.
  - Predictor prev=0, pipeline valids=0, packer fill=0, idle counter=0.
  - Partial bits are discarded, including on a mid-stream reset.
- Prediction: e = (pixel_in - prev) mod 2^16, interpreted as signed 16-bit. prev <= pixel_in on each accepted pixel. The first pixel after reset or flush uses prev=0.
- Mapping: u = (e<<1) XOR (16 copies of e[15]), 16-bit unsigned. Maps 0,-1,1,-2 to 0,1,2,3.
- Coding, with q = u>>K and r = u[K-1:0]:
  - If q < ESC_Q: emit q ones, one zero, then r MSB-first. Length q+1+K.
  - Else: emit ESC_Q ones, then u as 16 raw bits MSB-first. Length ESC_Q+16.
- Packer:
  - 64-bit accumulator, fill count 0..63. New code bits are appended directly after existing bits.
  - When fill >= 32, the oldest 32 bits are registered to stream_out, valid_out=1, and fill -= 32.
  - Fill before append is always < 32, so at most one word is emitted per cycle and no stall is needed.
- Latency: a pixel sampled at clock edge T has its mapped value registered at T, its code registered at T+1, and is packed at T+2. A word completed by that pixel is visible on stream_out/valid_out after edge T+2, i.e. sampled by a bench at edge T+3.
- Idle flush:
  - The idle counter increments on each cycle with valid_in=0 and an empty pipeline. It clears on valid_in=1.
  - When the counter reaches FLUSH_IDLE and fill > 0, the remaining bits are emitted left-justified with zero padding in the LSBs. Then fill=0, prev=0, counter=0.
  - Each flushed segment therefore decodes standalone.
  - If fill==0, no word is emitted (except as described under the optional feature).
- A valid_in arriving on the flush cycle is accepted normally. The flush uses the pre-append contents, and the new pixel predicts from prev=0.
- valid_out is 0 on all non-emitting cycles. stream_out holds its last value.

Optional Feature:
- Macro LWIR_SEGMENT_TRAILER_EN.
- When defined:
  - A 16-bit pixel counter (mod 2^16) counts accepted pixels since the last reset/flush.
  - Flush triggers when fill>0 or count>0.
  - After the padded data word (if any), the next cycle emits trailer word {16'hA5C3, count}. The count then clears.
  - Inputs accepted during the trailer cycle are handled normally. The trailer must not collide with a data word; a pending data word is delayed one cycle, which the accumulator headroom guarantees is possible.
- When undefined: no counter and no trailer words.

Test Plan:
- Reset, single pixel 0x0003, idle 12 cycles -> one flushed word 0x30000000 (u=6: "0 0110"), valid_out high for exactly one cycle.
- Reset, pixel 0x0100 -> escape code with 16 ones plus 0x0200 gives fill exactly 32 -> 0xFFFF0200 at edge T+3; nothing emitted on flush.
- Pixels 0x0005, 0x0004, then idle -> u=10,1 -> flushed word 0x50400000.
- Wrap case: 0xFFFF then 0x0000, then idle -> u=1,2 -> 0x08800000.
- Eight pixels of 0x0010 (42 bits) -> word 0xC0000000 on the pipeline output, then flush word 0x00000000. With LWIR_SEGMENT_TRAILER_EN, an additional 0xA5C30008 follows.
- Assert rst mid-stream after 3 pixels with fill>0 -> no output, valid_out=0. A subsequent pixel 0x0003 reproduces 0x30000000, proving prev and fill were cleared.
